// File: rtl/control.sv
// -----------------------------------------------------------------------------
// control -- single-cycle MIPS-subset instruction decoder
//
// Splits the current instruction into register addresses, immediate, shift
// amount and jump target. It also produces the ALU controls and the
// write/jump/branch strobes for a single-cycle datapath. Decode is purely
// combinational. The only state is a sticky flag that records when an
// unsupported instruction has been seen.
//
// Ports:
//   reg_write   out  1   register-file write enable
//   alu_src     out  2   ALU B-operand select (ALU_SRC_*)
//   alu_op      out  3   ALU operation (OP_*)
//   addr_a      out  5   register-file read port A address
//   addr_b      out  5   register-file read port B address
//   addr_in     out  5   register-file write address
//   shamt       out  5   shift amount (non-zero only for sll/srl)
//   imm16       out  16  raw immediate, instruction[15:0]
//   addr26      out  26  jump target, instruction[25:0]
//   is_jump     out  1   unconditional jump (j, jr)
//   is_branch   out  1   conditional branch (beq, bne)
//   instruction in   32  current instruction
//   clk         in   1   clock, used only by bad_instr
//   reset       in   1   asynchronous active-high reset
//   bad_instr   out  1   sticky: an unsupported instruction was decoded
// -----------------------------------------------------------------------------
module control (
   output logic        reg_write,
   output logic [1:0]  alu_src,
   output logic [2:0]  alu_op,
   output logic [4:0]  addr_a,
   output logic [4:0]  addr_b,
   output logic [4:0]  addr_in,
   output logic [4:0]  shamt,
   output logic [15:0] imm16,
   output logic [25:0] addr26,
   output logic        is_jump,
   output logic        is_branch,
   input  logic [31:0] instruction,
   input  logic        clk,
   input  logic        reset,
   output logic        bad_instr
);

   // ALU B-operand select encodings
   localparam logic [1:0] ALU_SRC_REG_B      = 2'd0;
   localparam logic [1:0] ALU_SRC_SEXT_IMM16 = 2'd1;
   localparam logic [1:0] ALU_SRC_ZEXT_IMM16 = 2'd2;
   localparam logic [1:0] ALU_SRC_SHAMT      = 2'd3;

   // ALU operation encodings
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_NOR = 3'd4;
   localparam logic [2:0] OP_SLT = 3'd5;
   localparam logic [2:0] OP_SLL = 3'd6;
   localparam logic [2:0] OP_SRL = 3'd7;

   logic [5:0] op;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [4:0] rd;
   logic [4:0] sa;
   logic [5:0] funct;

   assign op    = instruction[31:26];
   assign rs    = instruction[25:21];
   assign rt    = instruction[20:16];
   assign rd    = instruction[15:11];
   assign sa    = instruction[10:6];
   assign funct = instruction[5:0];

   assign imm16  = instruction[15:0];
   assign addr26 = instruction[25:0];

   // Ungated strobes; reset masking is applied afterwards.
   logic reg_write_raw;
   logic is_jump_raw;
   logic is_branch_raw;
   logic unsupported;

   always_comb begin
      reg_write_raw = 1'b0;
      is_jump_raw   = 1'b0;
      is_branch_raw = 1'b0;
      alu_op        = OP_ADD;
      alu_src       = ALU_SRC_REG_B;
      addr_a        = rs;
      addr_b        = rt;
      addr_in       = rd;
      shamt         = 5'd0;
      unsupported   = 1'b0;

      case (op)
         6'h00: begin
            case (funct)
               6'h20: begin reg_write_raw = 1'b1; alu_op = OP_ADD; end
               6'h22: begin reg_write_raw = 1'b1; alu_op = OP_SUB; end
               6'h24: begin reg_write_raw = 1'b1; alu_op = OP_AND; end
               6'h25: begin reg_write_raw = 1'b1; alu_op = OP_OR;  end
               6'h27: begin reg_write_raw = 1'b1; alu_op = OP_NOR; end
               6'h2A: begin reg_write_raw = 1'b1; alu_op = OP_SLT; end
               // Shifts take the shifted operand (rt) on port A.
               6'h00, 6'h02: begin
                  reg_write_raw = 1'b1;
                  alu_op        = (funct == 6'h00) ? OP_SLL : OP_SRL;
                  alu_src       = ALU_SRC_SHAMT;
                  addr_a        = rt;
                  shamt         = sa;
               end
               6'h08: is_jump_raw = 1'b1;  // jr: target comes from rs on port A
               default: unsupported = 1'b1;
            endcase
         end
         6'h08: begin reg_write_raw = 1'b1; addr_in = rt; alu_op = OP_ADD; alu_src = ALU_SRC_SEXT_IMM16; end
         6'h0C: begin reg_write_raw = 1'b1; addr_in = rt; alu_op = OP_AND; alu_src = ALU_SRC_ZEXT_IMM16; end
         6'h0D: begin reg_write_raw = 1'b1; addr_in = rt; alu_op = OP_OR;  alu_src = ALU_SRC_ZEXT_IMM16; end
         6'h0A: begin reg_write_raw = 1'b1; addr_in = rt; alu_op = OP_SLT; alu_src = ALU_SRC_SEXT_IMM16; end
         6'h04, 6'h05: begin
            is_branch_raw = 1'b1;
            alu_op        = OP_SUB;
         end
         6'h02: is_jump_raw = 1'b1;
         default: unsupported = 1'b1;
      endcase
   end

   // Strobes are held low during reset so no architectural state changes;
   // the field outputs keep decoding.
   assign reg_write = reg_write_raw & ~reset;
   assign is_jump   = is_jump_raw   & ~reset;
   assign is_branch = is_branch_raw & ~reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         bad_instr <= 1'b0;
      else if (unsupported)
         bad_instr <= 1'b1;
   end

endmodule

// File: tb/tb_control.sv
// -----------------------------------------------------------------------------
// tb_control -- directed self-checking bench for the control decoder
// -----------------------------------------------------------------------------
module tb_control;

   localparam logic [1:0] S_REG  = 2'd0;
   localparam logic [1:0] S_SEXT = 2'd1;
   localparam logic [1:0] S_ZEXT = 2'd2;
   localparam logic [1:0] S_SHA  = 2'd3;

   localparam logic [2:0] A_ADD = 3'd0;
   localparam logic [2:0] A_SUB = 3'd1;
   localparam logic [2:0] A_AND = 3'd2;
   localparam logic [2:0] A_OR  = 3'd3;
   localparam logic [2:0] A_NOR = 3'd4;
   localparam logic [2:0] A_SLT = 3'd5;
   localparam logic [2:0] A_SLL = 3'd6;
   localparam logic [2:0] A_SRL = 3'd7;

   logic        clk;
   logic        reset;
   logic [31:0] instruction;
   logic        reg_write;
   logic [1:0]  alu_src;
   logic [2:0]  alu_op;
   logic [4:0]  addr_a;
   logic [4:0]  addr_b;
   logic [4:0]  addr_in;
   logic [4:0]  shamt;
   logic [15:0] imm16;
   logic [25:0] addr26;
   logic        is_jump;
   logic        is_branch;
   logic        bad_instr;

   int checks = 0;
   int errors = 0;

   control dut (
      .reg_write   (reg_write),
      .alu_src     (alu_src),
      .alu_op      (alu_op),
      .addr_a      (addr_a),
      .addr_b      (addr_b),
      .addr_in     (addr_in),
      .shamt       (shamt),
      .imm16       (imm16),
      .addr26      (addr26),
      .is_jump     (is_jump),
      .is_branch   (is_branch),
      .instruction (instruction),
      .clk         (clk),
      .reset       (reset),
      .bad_instr   (bad_instr)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one instruction and check every decode output against the
   // hand-computed expectation.
   task automatic dec(input string name, input logic [31:0] instr,
                      input logic rw, input logic [1:0] src, input logic [2:0] op,
                      input logic [4:0] a, input logic [4:0] b, input logic [4:0] in,
                      input logic [4:0] sh, input logic j, input logic br);
      instruction = instr;
      #1;
      check({name, ".reg_write"}, {31'd0, reg_write}, {31'd0, rw});
      check({name, ".alu_src"},   {30'd0, alu_src},   {30'd0, src});
      check({name, ".alu_op"},    {29'd0, alu_op},    {29'd0, op});
      check({name, ".addr_a"},    {27'd0, addr_a},    {27'd0, a});
      check({name, ".addr_b"},    {27'd0, addr_b},    {27'd0, b});
      check({name, ".addr_in"},   {27'd0, addr_in},   {27'd0, in});
      check({name, ".shamt"},     {27'd0, shamt},     {27'd0, sh});
      check({name, ".is_jump"},   {31'd0, is_jump},   {31'd0, j});
      check({name, ".is_branch"}, {31'd0, is_branch}, {31'd0, br});
   endtask

   initial begin
      reset       = 1'b1;
      instruction = 32'h00A63824;  // and $7,$5,$6
      #12;
      check("reset.bad_instr", {31'd0, bad_instr}, 32'd0);
      dec("reset_and", 32'h00A63824, 1'b0, S_REG, A_AND, 5'd5, 5'd6, 5'd7, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;

      dec("addi", 32'h2010FEFE, 1'b1, S_SEXT, A_ADD, 5'd0, 5'd16, 5'd16, 5'd0, 1'b0, 1'b0);
      check("addi.imm16", {16'd0, imm16}, 32'h0000FEFE);
      dec("sll",  32'h00108400, 1'b1, S_SHA, A_SLL, 5'd16, 5'd16, 5'd16, 5'd16, 1'b0, 1'b0);
      dec("srl",  32'h00104042, 1'b1, S_SHA, A_SRL, 5'd16, 5'd16, 5'd8, 5'd1, 1'b0, 1'b0);
      dec("sub",  32'h02114022, 1'b1, S_REG, A_SUB, 5'd16, 5'd17, 5'd8, 5'd0, 1'b0, 1'b0);
      dec("slt",  32'h0111482A, 1'b1, S_REG, A_SLT, 5'd8, 5'd17, 5'd9, 5'd0, 1'b0, 1'b0);
      dec("and",  32'h00A63824, 1'b1, S_REG, A_AND, 5'd5, 5'd6, 5'd7, 5'd0, 1'b0, 1'b0);
      dec("or",   32'h00A63825, 1'b1, S_REG, A_OR,  5'd5, 5'd6, 5'd7, 5'd0, 1'b0, 1'b0);
      dec("nor",  32'h00A63827, 1'b1, S_REG, A_NOR, 5'd5, 5'd6, 5'd7, 5'd0, 1'b0, 1'b0);
      // add with a non-zero sa field: shamt must still be 0
      dec("add_sa", 32'h00A638E0, 1'b1, S_REG, A_ADD, 5'd5, 5'd6, 5'd7, 5'd0, 1'b0, 1'b0);
      dec("andi", 32'h320900CF, 1'b1, S_ZEXT, A_AND, 5'd16, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
      check("andi.imm16", {16'd0, imm16}, 32'h000000CF);
      dec("ori",  32'h360900C0, 1'b1, S_ZEXT, A_OR, 5'd16, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
      check("ori.imm16", {16'd0, imm16}, 32'h000000C0);
      dec("slti", 32'h2864FFFF, 1'b1, S_SEXT, A_SLT, 5'd3, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
      dec("j",    32'h08000004, 1'b0, S_REG, A_ADD, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      check("j.addr26", {6'd0, addr26}, 32'h00000004);
      dec("jr",   32'h03E00008, 1'b0, S_REG, A_ADD, 5'd31, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      dec("bne",  32'h154BFFFC, 1'b0, S_REG, A_SUB, 5'd10, 5'd11, 5'd31, 5'd0, 1'b0, 1'b1);
      dec("beq",  32'h114BFFFC, 1'b0, S_REG, A_SUB, 5'd10, 5'd11, 5'd31, 5'd0, 1'b0, 1'b1);
      check("legal.bad_instr", {31'd0, bad_instr}, 32'd0);

      // Illegal opcode 0x3F: defaults, flag rises only at the next edge
      @(negedge clk);
      dec("ill_op", 32'hFC000000, 1'b0, S_REG, A_ADD, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      check("ill.pre_edge", {31'd0, bad_instr}, 32'd0);
      @(posedge clk);
      #1;
      check("ill.post_edge", {31'd0, bad_instr}, 32'd1);

      // Flag is sticky across legal instructions
      @(negedge clk);
      instruction = 32'h2010FEFE;
      repeat (3) @(posedge clk);
      #1;
      check("ill.sticky", {31'd0, bad_instr}, 32'd1);

      // Asynchronous clear, mid-cycle with no clock edge in between
      @(negedge clk);
      #2;
      reset = 1'b1;
      instruction = 32'h00A638E0;
      #1;
      check("async_clear", {31'd0, bad_instr}, 32'd0);
      check("reset.add.reg_write", {31'd0, reg_write}, 32'd0);
      check("reset.add.addr_in", {27'd0, addr_in}, 32'd7);

      // Reset wins over an unsupported instruction across an edge
      instruction = 32'h00A63821;  // funct 0x21, unsupported
      @(posedge clk);
      #1;
      check("reset_wins", {31'd0, bad_instr}, 32'd0);
      dec("ill_funct", 32'h00A63821, 1'b0, S_REG, A_ADD, 5'd5, 5'd6, 5'd7, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("ill_funct.pre_edge", {31'd0, bad_instr}, 32'd0);
      @(posedge clk);
      #1;
      check("ill_funct.post_edge", {31'd0, bad_instr}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
